// File: rtl/ay_bus_master.sv
// AY-3-891x bus master: runs one command as ADDR, GAP1, DATA, GAP2 phases on a
// registered BDIR/BC1/BC2 bus. Define AYBM_READ_EN to enable register reads.
module ay_bus_master #(
    parameter int T_ADDR = 8,
    parameter int T_DATA = 8,
    parameter int T_GAP  = 2
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic [1:0] cmd_chip,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       aybdir,
    output logic       aybc1,
    output logic       aybc2,
    output logic       aya8,
    output logic       aya9_n,
    output logic [7:0] ayd_o,
    output logic       ayd_oe,
    input  logic [7:0] ayd_i
);

    typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2} state_t;

    localparam logic [7:0] LD_ADDR = 8'(T_ADDR - 1);
    localparam logic [7:0] LD_DATA = 8'(T_DATA - 1);
    localparam logic [7:0] LD_GAP  = 8'(T_GAP - 1);

    state_t     state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic       rd_r, rd_s;
    logic [7:0] wdata_r, wdata_s;
    logic [7:0] sample_s;
    logic       accept_s;
    logic       ready_s, rsp_s, bdir_s, bc1_s, oe_s, a8_s, a9n_s;
    logic [7:0] dout_s, rdata_s;

`ifdef AYBM_READ_EN
    logic [7:0] sample_r;
`else
    logic       unused_ayd_i;
    assign unused_ayd_i = ^ayd_i;
`endif

    assign accept_s = cmd_valid & cmd_ready;
    assign aybc2    = 1'b1;

    // Next-state, phase counter and next values for every registered output
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rd_s     = rd_r;
        wdata_s  = wdata_r;
`ifdef AYBM_READ_EN
        sample_s = sample_r;
`else
        sample_s = 8'hFF;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ADDR;
                    cnt_s   = LD_ADDR;
                    rd_s    = cmd_rd;
                    wdata_s = cmd_wdata;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (cnt_r == 8'd0) begin
                    state_s = GAP1;
                    cnt_s   = LD_GAP;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            GAP1: begin
                if (cnt_r == 8'd0) begin
`ifdef AYBM_READ_EN
                    state_s = DATA;
                    cnt_s   = LD_DATA;
`else
                    // Reads end here when the read path is compiled out
                    if (rd_r) begin
                        state_s = IDLE;
                        cnt_s   = 8'd0;
                    end else begin
                        state_s = DATA;
                        cnt_s   = LD_DATA;
                    end
`endif
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            DATA: begin
                if (cnt_r == 8'd0) begin
                    state_s = GAP2;
                    cnt_s   = LD_GAP;
`ifdef AYBM_READ_EN
                    if (rd_r) begin
                        sample_s = ayd_i;
                    end else begin
                        sample_s = sample_r;
                    end
`endif
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            GAP2: begin
                if (cnt_r == 8'd0) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 8'd0;
            end
        endcase

        ready_s = (state_s == IDLE);
        case (state_s)
            ADDR: begin
                bdir_s = 1'b1;
                bc1_s  = 1'b1;
                oe_s   = 1'b1;
            end
            DATA: begin
                bdir_s = ~rd_r;
                bc1_s  = rd_r;
                oe_s   = ~rd_r;
            end
            default: begin
                bdir_s = 1'b0;
                bc1_s  = 1'b0;
                oe_s   = 1'b0;
            end
        endcase

        if (accept_s) begin
            dout_s = cmd_addr;
        end else if (state_s == DATA && !rd_r) begin
            dout_s = wdata_r;
        end else begin
            dout_s = ayd_o;
        end

        if (accept_s) begin
            {a9n_s, a8_s} = cmd_chip;
        end else begin
            {a9n_s, a8_s} = {aya9_n, aya8};
        end

        // Response lands on the last cycle of the final gap of the transaction
`ifdef AYBM_READ_EN
        rsp_s = (state_s == GAP2) && (cnt_s == 8'd0);
`else
        rsp_s = ((state_s == GAP2) || (state_s == GAP1 && rd_r)) && (cnt_s == 8'd0);
`endif
        if (rsp_s) begin
            rdata_s = rd_r ? sample_s : 8'h00;
        end else begin
            rdata_s = rsp_rdata;
        end
    end

    // State, command latch and output registers
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            rd_r      <= 1'b0;
            wdata_r   <= 8'h00;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            aybdir    <= 1'b0;
            aybc1     <= 1'b0;
            aya8      <= 1'b0;
            aya9_n    <= 1'b1;
            ayd_o     <= 8'h00;
            ayd_oe    <= 1'b0;
`ifdef AYBM_READ_EN
            sample_r  <= 8'h00;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rd_r      <= rd_s;
            wdata_r   <= wdata_s;
            cmd_ready <= ready_s;
            rsp_valid <= rsp_s;
            rsp_rdata <= rdata_s;
            aybdir    <= bdir_s;
            aybc1     <= bc1_s;
            aya8      <= a8_s;
            aya9_n    <= a9n_s;
            ayd_o     <= dout_s;
            ayd_oe    <= oe_s;
`ifdef AYBM_READ_EN
            sample_r  <= sample_s;
`endif
        end
    end

endmodule
